// File: rtl/if_stage.sv
// Instruction fetch: PC owner, single-outstanding imem fetch, valid/ready out with 1-entry skid; JAL predict under IF_JAL_PREDICT_EN.
// Latency: zero-wait memory yields one instruction per 2 cycles; redirect reaches the imem address 1 cycle later.
// Backpressure: a stalled output slot spills one response into the skid; requests stop while the skid is full.
module if_stage #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_o,
  output logic [XLEN-1:0]     imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [INST_LEN-1:0] imem_rdata_i,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  input  logic                id_ready_i,
  output logic                if_valid_o,
  output logic [XLEN-1:0]     if_pc_o,
  output logic [INST_LEN-1:0] if_instr_o,
  output logic                if_pred_taken_o
);

  typedef enum logic {ST_FETCH, ST_WAIT} state_t;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [INST_LEN-1:0] instr;
    logic                pred;
  } slot_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            discard_q, discard_d;
  logic            out_vld_q, out_vld_d;
  slot_t           out_q, out_d;
  logic            skid_vld_q, skid_vld_d;
  slot_t           skid_q, skid_d;

  logic            req;
  logic            accept;
  logic            slot_free;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] redirect_target;
  slot_t           new_slot;

  assign redirect_target = redirect_pc_i & ALIGN_MASK;

`ifdef IF_JAL_PREDICT_EN
  logic            is_jal;
  logic [20:0]     jimm;
  logic [XLEN-1:0] jal_sum;

  assign is_jal  = (imem_rdata_i[6:0] == 7'b1101111);
  assign jimm    = {imem_rdata_i[31], imem_rdata_i[19:12], imem_rdata_i[20],
                    imem_rdata_i[30:21], 1'b0};
  assign jal_sum = pc_q + {{(XLEN-21){jimm[20]}}, jimm};
  assign next_pc = is_jal ? (jal_sum & ALIGN_MASK) : (pc_q + XLEN'(4));
  assign new_slot = '{pc: pc_q, instr: imem_rdata_i, pred: is_jal};
`else
  assign next_pc  = pc_q + XLEN'(4);
  assign new_slot = '{pc: pc_q, instr: imem_rdata_i, pred: 1'b0};
`endif

  // Request is masked during reset so nothing escapes before the core is live.
  assign req         = (state_q == ST_FETCH) && !skid_vld_q && rst_n;
  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    accept    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (req && imem_gnt_i) begin
          state_d   = ST_WAIT;
          discard_d = redirect_i;
        end
        if (redirect_i) pc_d = redirect_target;
      end
      ST_WAIT: begin
        if (redirect_i) begin
          pc_d = redirect_target;
          if (imem_rvalid_i) begin
            state_d   = ST_FETCH;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          state_d   = ST_FETCH;
          discard_d = 1'b0;
          if (!discard_q) begin
            accept = 1'b1;
            pc_d   = next_pc;
          end
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign slot_free = !out_vld_q || id_ready_i;

  // Skid drains ahead of fresh data so delivery stays in fetch order.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (redirect_i) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (slot_free) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = accept;
        if (accept) skid_d = new_slot;
      end else if (accept) begin
        out_d     = new_slot;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = new_slot;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end

  assign if_valid_o      = out_vld_q;
  assign if_pc_o         = out_q.pc;
  assign if_instr_o      = out_q.instr;
  assign if_pred_taken_o = out_q.pred;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a scripted one-outstanding imem responder.
module tb_if_stage;
  localparam int XLEN = 64;
  localparam int INST_LEN = 32;
`ifdef IF_JAL_PREDICT_EN
  localparam logic [63:0] JAL_NEXT = 64'h8000_0010;
  localparam logic        JAL_PRED = 1'b1;
  localparam logic [31:0] JAL_NEXT_INSTR = 32'h0040_0013;
`else
  localparam logic [63:0] JAL_NEXT = 64'h8000_0004;
  localparam logic        JAL_PRED = 1'b0;
  localparam logic [31:0] JAL_NEXT_INSTR = 32'h0010_0013;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                imem_req_o;
  logic [XLEN-1:0]     imem_addr_o;
  logic                imem_gnt_i = 1'b0;
  logic                imem_rvalid_i = 1'b0;
  logic [INST_LEN-1:0] imem_rdata_i = '0;
  logic                redirect_i = 1'b0;
  logic [XLEN-1:0]     redirect_pc_i = '0;
  logic                id_ready_i = 1'b0;
  logic                if_valid_o;
  logic [XLEN-1:0]     if_pc_o;
  logic [INST_LEN-1:0] if_instr_o;
  logic                if_pred_taken_o;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .id_ready_i(id_ready_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o),
    .if_pred_taken_o(if_pred_taken_o)
  );

  int total = 0;
  int bad = 0;

  logic        gnt_en = 1'b1;
  int          rv_lat = 1;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_data = '0;
  bit          jal_mode = 1'b0;
  logic [63:0] gq[$];
  logic [63:0] dq_pc[$];
  logic [31:0] dq_instr[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (jal_mode && a == 64'h8000_0000) return 32'h0100_006F;
    return {a[13:2], 20'h00013};
  endfunction

  // Logs the transfer due at the coming edge, then updates the memory model 2 ns after it.
  task automatic step();
    if (if_valid_o && id_ready_i) begin
      dq_pc.push_back(if_pc_o);
      dq_instr.push_back(if_instr_o);
    end
    @(posedge clk);
    #2;
    if (!rst_n) begin
      pend = 1'b0;
      imem_gnt_i = 1'b0;
      imem_rvalid_i = 1'b0;
    end else begin
      if (pend && pend_cnt == 1) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i = pend_data;
        pend = 1'b0;
      end else begin
        imem_rvalid_i = 1'b0;
        if (pend) pend_cnt--;
      end
      if (imem_req_o && gnt_en) begin
        imem_gnt_i = 1'b1;
        pend = 1'b1;
        pend_cnt = rv_lat;
        pend_data = mem_word(imem_addr_o);
        gq.push_back(imem_addr_o);
      end else begin
        imem_gnt_i = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    id_ready_i = rdy;
    gnt_en = 1'b1;
    rv_lat = 1;
    jal_mode = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    gq.delete();
    dq_pc.delete();
    dq_instr.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    id_ready_i = 1'b1;
    repeat (2) step();
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req_o); end
    total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid_o); end
    total++; if (if_pc_o !== 64'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", if_pc_o); end
    total++; if (if_instr_o !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", if_instr_o); end
    total++; if (if_pred_taken_o !== 1'b0) begin bad++; $display("FAIL reset_pred got=%b exp=0", if_pred_taken_o); end
    total++; if (imem_addr_o !== 64'h8000_0000) begin bad++; $display("FAIL reset_addr got=%h exp=80000000", imem_addr_o); end
    rst_n = 1'b1;
    #1;
    total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL release_req got=%b exp=1", imem_req_o); end
  endtask

  task automatic test_fetch();
    do_reset(1'b1);
    repeat (12) step();
    total++; if (gq.size() < 3) begin bad++; $display("FAIL fetch_grants got=%0d exp>=3", gq.size()); end
    else begin
      total++; if (gq[0] !== 64'h8000_0000) begin bad++; $display("FAIL fetch_addr0 got=%h exp=80000000", gq[0]); end
      total++; if (gq[1] !== 64'h8000_0004) begin bad++; $display("FAIL fetch_addr1 got=%h exp=80000004", gq[1]); end
      total++; if (gq[2] !== 64'h8000_0008) begin bad++; $display("FAIL fetch_addr2 got=%h exp=80000008", gq[2]); end
    end
    total++; if (dq_pc.size() != 5) begin bad++; $display("FAIL fetch_throughput got=%0d exp=5", dq_pc.size()); end
    if (dq_pc.size() >= 2) begin
      total++; if (dq_pc[0] !== 64'h8000_0000 || dq_instr[0] !== 32'h0000_0013) begin
        bad++; $display("FAIL fetch_first got=%h/%h exp=80000000/00000013", dq_pc[0], dq_instr[0]); end
      total++; if (dq_pc[1] !== 64'h8000_0004 || dq_instr[1] !== 32'h0010_0013) begin
        bad++; $display("FAIL fetch_second got=%h/%h exp=80000004/00100013", dq_pc[1], dq_instr[1]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    repeat (8) step();
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL bp_req got=%b exp=0", imem_req_o); end
    total++; if (if_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", if_valid_o); end
    total++; if (if_pc_o !== 64'h8000_0000 || if_instr_o !== 32'h0000_0013) begin
      bad++; $display("FAIL bp_hold got=%h/%h exp=80000000/00000013", if_pc_o, if_instr_o); end
    total++; if (gq.size() != 2) begin bad++; $display("FAIL bp_grants got=%0d exp=2", gq.size()); end
    id_ready_i = 1'b1;
    repeat (10) step();
    total++; if (dq_pc.size() < 3) begin bad++; $display("FAIL bp_count got=%0d exp>=3", dq_pc.size()); end
    else begin
      total++; if (dq_pc[0] !== 64'h8000_0000 || dq_instr[0] !== 32'h0000_0013) begin
        bad++; $display("FAIL bp_order0 got=%h/%h exp=80000000/00000013", dq_pc[0], dq_instr[0]); end
      total++; if (dq_pc[1] !== 64'h8000_0004 || dq_instr[1] !== 32'h0010_0013) begin
        bad++; $display("FAIL bp_order1 got=%h/%h exp=80000004/00100013", dq_pc[1], dq_instr[1]); end
      total++; if (dq_pc[2] !== 64'h8000_0008 || dq_instr[2] !== 32'h0020_0013) begin
        bad++; $display("FAIL bp_order2 got=%h/%h exp=80000008/00200013", dq_pc[2], dq_instr[2]); end
    end
  endtask

  task automatic test_redirect_wait();
    do_reset(1'b1);
    rv_lat = 3;
    repeat (2) step();
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rw_inwait got=%b exp=0", imem_req_o); end
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_1002;
    step();
    redirect_i = 1'b0;
    total++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      bad++; $display("FAIL rw_discarding got=%b/%b exp=0/0", if_valid_o, imem_req_o); end
    repeat (2) step();
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_1000) begin
      bad++; $display("FAIL rw_newreq got=%b/%h exp=1/80001000", imem_req_o, imem_addr_o); end
    repeat (8) step();
    total++; if (dq_pc.size() != 1) begin bad++; $display("FAIL rw_count got=%0d exp=1", dq_pc.size()); end
    else begin
      total++; if (dq_pc[0] !== 64'h8000_1000 || dq_instr[0] !== 32'h4000_0013) begin
        bad++; $display("FAIL rw_first got=%h/%h exp=80001000/40000013", dq_pc[0], dq_instr[0]); end
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset(1'b0);
    repeat (4) step();
    total++; if (if_valid_o !== 1'b1 || imem_rvalid_i !== 1'b1) begin
      bad++; $display("FAIL rr_setup got=%b/%b exp=1/1", if_valid_o, imem_rvalid_i); end
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_2000;
    step();
    redirect_i = 1'b0;
    id_ready_i = 1'b1;
    total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL rr_flush got=%b exp=0", if_valid_o); end
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_2000) begin
      bad++; $display("FAIL rr_newreq got=%b/%h exp=1/80002000", imem_req_o, imem_addr_o); end
    repeat (4) step();
    total++; if (dq_pc.size() != 1) begin bad++; $display("FAIL rr_count got=%0d exp=1", dq_pc.size()); end
    else begin
      total++; if (dq_pc[0] !== 64'h8000_2000 || dq_instr[0] !== 32'h8000_0013) begin
        bad++; $display("FAIL rr_first got=%h/%h exp=80002000/80000013", dq_pc[0], dq_instr[0]); end
    end
  endtask

  task automatic test_redirect_gnt();
    do_reset(1'b1);
    step();
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_3000;
    step();
    redirect_i = 1'b0;
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rg_wait got=%b exp=0", imem_req_o); end
    step();
    total++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_3000) begin
      bad++; $display("FAIL rg_after_drop got=%b/%b/%h exp=0/1/80003000", if_valid_o, imem_req_o, imem_addr_o); end
    repeat (4) step();
    total++; if (dq_pc.size() != 1) begin bad++; $display("FAIL rg_count got=%0d exp=1", dq_pc.size()); end
    else begin
      total++; if (dq_pc[0] !== 64'h8000_3000 || dq_instr[0] !== 32'hC000_0013) begin
        bad++; $display("FAIL rg_first got=%h/%h exp=80003000/c0000013", dq_pc[0], dq_instr[0]); end
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    gnt_en = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    redirect_i = 1'b0;
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      bad++; $display("FAIL wrap_abandon got=%b/%h exp=1/fffffffffffffffc", imem_req_o, imem_addr_o); end
    gnt_en = 1'b1;
    repeat (3) step();
    total++; if (imem_addr_o !== 64'h0) begin bad++; $display("FAIL wrap_next got=%h exp=0", imem_addr_o); end
    total++; if (if_valid_o !== 1'b1 || if_pc_o !== 64'hFFFF_FFFF_FFFF_FFFC || if_instr_o !== 32'hFFF0_0013) begin
      bad++; $display("FAIL wrap_out got=%b/%h/%h exp=1/fffffffffffffffc/fff00013", if_valid_o, if_pc_o, if_instr_o); end
  endtask

  task automatic test_jal();
    do_reset(1'b0);
    jal_mode = 1'b1;
    repeat (3) step();
    total++; if (if_pc_o !== 64'h8000_0000 || if_instr_o !== 32'h0100_006F) begin
      bad++; $display("FAIL jal_out got=%h/%h exp=80000000/0100006f", if_pc_o, if_instr_o); end
    total++; if (if_pred_taken_o !== JAL_PRED) begin bad++; $display("FAIL jal_pred got=%b exp=%b", if_pred_taken_o, JAL_PRED); end
    total++; if (imem_addr_o !== JAL_NEXT) begin bad++; $display("FAIL jal_next got=%h exp=%h", imem_addr_o, JAL_NEXT); end
    repeat (2) step();
    id_ready_i = 1'b1;
    step();
    total++; if (if_pc_o !== JAL_NEXT || if_instr_o !== JAL_NEXT_INSTR || if_pred_taken_o !== 1'b0) begin
      bad++; $display("FAIL jal_follow got=%h/%h/%b exp=%h/%h/0", if_pc_o, if_instr_o, if_pred_taken_o, JAL_NEXT, JAL_NEXT_INSTR); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid();
    test_redirect_gnt();
    test_wrap();
    test_jal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
